// File: rtl/kernel_job_sched.sv
// -----------------------------------------------------------------------------
// kernel_job_sched
//
// Job scheduler for a single vector_add kernel instance. Job descriptors are
// queued in a small FIFO. They are launched one at a time through the kernel
// start/done handshake, and each completion is returned as a result record.
//
// Optional feature: define KSCHED_TIMEOUT_EN to enable the RUN watchdog. When
// a launch has run for TIMEOUT_CYC cycles without k_done, the kernel is
// aborted with a one-cycle soft-reset pulse and a timeout record is produced.
// Without the macro there is no counter, and k_soft_reset / res_status read 0.
//
// Parameters
//   JOB_DEPTH    job FIFO entries (power of 2, >= 2)
//   TAG_W        width of the per-launch sequence tag
//   TIMEOUT_CYC  watchdog limit in RUN cycles (KSCHED_TIMEOUT_EN only)
//
// Ports
//   i_clock, i_reset     clock; synchronous active-high reset
//   i_job_valid/o_job_ready/i_job_bits
//                        descriptor push {pargs,pdata,pres,args_len,data_len}
//   o_k_start, i_k_done, i_k_ap_return
//                        kernel launch handshake and return value
//   o_k_pargs .. o_k_data_len
//                        kernel arguments, held stable for the whole run
//   o_k_soft_reset       one-cycle kernel abort pulse (timeout only)
//   o_res_valid/i_res_ready/o_res_return/o_res_tag/o_res_status
//                        completion record handshake
//   o_busy               scheduler active or jobs queued
//   o_jobs_done          count of consumed completion records (wraps)
// -----------------------------------------------------------------------------
module kernel_job_sched #(
   parameter int JOB_DEPTH   = 4,
   parameter int TAG_W       = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_job_valid,
   output logic             o_job_ready,
   input  logic [255:0]     i_job_bits,
   output logic             o_k_start,
   input  logic             i_k_done,
   input  logic [31:0]      i_k_ap_return,
   output logic [63:0]      o_k_pargs,
   output logic [63:0]      o_k_pdata,
   output logic [63:0]      o_k_pres,
   output logic [31:0]      o_k_args_len,
   output logic [31:0]      o_k_data_len,
   output logic             o_k_soft_reset,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [31:0]      o_res_return,
   output logic [TAG_W-1:0] o_res_tag,
   output logic             o_res_status,
   output logic             o_busy,
   output logic [15:0]      o_jobs_done
);

   localparam int PTR_W = $clog2(JOB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Job FIFO
   // ---------------------------------------------------------------------------
   logic [255:0]     r_mem [JOB_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [255:0]     w_head;

   state_t           r_state;

   assign w_full  = (r_count == CNT_W'(JOB_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = i_job_valid && !w_full;
   // The head is only consumed when the FSM launches from IDLE. A job pushed
   // into an empty FIFO is therefore first visible one edge after acceptance.
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   assign w_head  = r_mem[r_rd_ptr];

   // Payload storage carries no reset; validity is tracked by r_count.
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_job_bits;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // ---------------------------------------------------------------------------
   // Launch / completion FSM (all outputs registered)
   // ---------------------------------------------------------------------------
   logic             r_k_start;
   logic [63:0]      r_k_pargs;
   logic [63:0]      r_k_pdata;
   logic [63:0]      r_k_pres;
   logic [31:0]      r_k_args_len;
   logic [31:0]      r_k_data_len;
   logic             r_res_valid;
   logic [31:0]      r_res_return;
   logic [TAG_W-1:0] r_res_tag;
   logic [TAG_W-1:0] r_tag;
   logic [15:0]      r_jobs_done;
`ifdef KSCHED_TIMEOUT_EN
   logic [31:0]      r_run_cnt;
   logic             r_k_soft_reset;
   logic             r_res_status;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_k_start    <= 1'b0;
         r_k_pargs    <= '0;
         r_k_pdata    <= '0;
         r_k_pres     <= '0;
         r_k_args_len <= '0;
         r_k_data_len <= '0;
         r_res_valid  <= 1'b0;
         r_res_return <= '0;
         r_res_tag    <= '0;
         r_tag        <= '0;
         r_jobs_done  <= '0;
`ifdef KSCHED_TIMEOUT_EN
         r_run_cnt      <= '0;
         r_k_soft_reset <= 1'b0;
         r_res_status   <= 1'b0;
`endif
      end else begin
`ifdef KSCHED_TIMEOUT_EN
         // Abort pulse lasts exactly one cycle.
         r_k_soft_reset <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_k_pargs    <= w_head[255:192];
                  r_k_pdata    <= w_head[191:128];
                  r_k_pres     <= w_head[127:64];
                  r_k_args_len <= w_head[63:32];
                  r_k_data_len <= w_head[31:0];
                  r_k_start    <= 1'b1;
                  r_state      <= S_RUN;
`ifdef KSCHED_TIMEOUT_EN
                  r_run_cnt    <= '0;
`endif
               end
            end

            S_RUN: begin
               // A completion on the expiry edge takes priority over timeout.
               if (i_k_done) begin
                  r_res_return <= i_k_ap_return;
                  r_res_tag    <= r_tag;
                  r_tag        <= r_tag + TAG_W'(1);
                  r_k_start    <= 1'b0;
                  r_res_valid  <= 1'b1;
                  r_state      <= S_REPORT;
`ifdef KSCHED_TIMEOUT_EN
                  r_res_status <= 1'b0;
`endif
               end
`ifdef KSCHED_TIMEOUT_EN
               // r_run_cnt holds completed RUN cycles minus one here, so the
               // abort fires on the TIMEOUT_CYC-th RUN edge.
               else if (r_run_cnt == 32'(TIMEOUT_CYC - 1)) begin
                  r_res_return   <= '0;
                  r_res_tag      <= r_tag;
                  r_tag          <= r_tag + TAG_W'(1);
                  r_k_start      <= 1'b0;
                  r_k_soft_reset <= 1'b1;
                  r_res_status   <= 1'b1;
                  r_res_valid    <= 1'b1;
                  r_state        <= S_REPORT;
               end else begin
                  r_run_cnt <= r_run_cnt + 32'd1;
               end
`endif
            end

            S_REPORT: begin
               // Only one record may be outstanding; launches wait for IDLE.
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_jobs_done <= r_jobs_done + 16'd1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------------
   assign o_job_ready  = !w_full;
   assign o_busy       = (r_state != S_IDLE) || !w_empty;
   assign o_k_start    = r_k_start;
   assign o_k_pargs    = r_k_pargs;
   assign o_k_pdata    = r_k_pdata;
   assign o_k_pres     = r_k_pres;
   assign o_k_args_len = r_k_args_len;
   assign o_k_data_len = r_k_data_len;
   assign o_res_valid  = r_res_valid;
   assign o_res_return = r_res_return;
   assign o_res_tag    = r_res_tag;
   assign o_jobs_done  = r_jobs_done;
`ifdef KSCHED_TIMEOUT_EN
   assign o_k_soft_reset = r_k_soft_reset;
   assign o_res_status   = r_res_status;
`else
   assign o_k_soft_reset = 1'b0;
   assign o_res_status   = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_job_sched.sv
// -----------------------------------------------------------------------------
// tb_kernel_job_sched
//
// Directed bench for kernel_job_sched. A queue-based reference model tracks
// what the scheduler must present each cycle; a compare process checks every
// DUT output against it on each falling edge once reset has been applied.
// Directed scenarios add literal expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_kernel_job_sched;

   localparam int DEPTH = 4;
   localparam int TAG_W = 8;
   localparam int TOC   = 100;

   logic             clk = 1'b0;
   logic             rst;
   logic             job_valid;
   logic             job_ready;
   logic [255:0]     job_bits;
   logic             k_start;
   logic             k_done;
   logic [31:0]      k_ap_return;
   logic [63:0]      k_pargs;
   logic [63:0]      k_pdata;
   logic [63:0]      k_pres;
   logic [31:0]      k_args_len;
   logic [31:0]      k_data_len;
   logic             k_soft_reset;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_return;
   logic [TAG_W-1:0] res_tag;
   logic             res_status;
   logic             busy;
   logic [15:0]      jobs_done;

   always #5 clk = ~clk;

   kernel_job_sched #(
      .JOB_DEPTH  (DEPTH),
      .TAG_W      (TAG_W),
      .TIMEOUT_CYC(TOC)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_job_valid   (job_valid),
      .o_job_ready   (job_ready),
      .i_job_bits    (job_bits),
      .o_k_start     (k_start),
      .i_k_done      (k_done),
      .i_k_ap_return (k_ap_return),
      .o_k_pargs     (k_pargs),
      .o_k_pdata     (k_pdata),
      .o_k_pres      (k_pres),
      .o_k_args_len  (k_args_len),
      .o_k_data_len  (k_data_len),
      .o_k_soft_reset(k_soft_reset),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_return  (res_return),
      .o_res_tag     (res_tag),
      .o_res_status  (res_status),
      .o_busy        (busy),
      .o_jobs_done   (jobs_done)
   );

   int n_pass = 0;
   int n_tot  = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [255:0] mkjob(input logic [63:0] pa, input logic [63:0] pd,
                                          input logic [63:0] pr, input logic [31:0] al,
                                          input logic [31:0] dl);
      return {pa, pd, pr, al, dl};
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model: queued jobs, current job, and an outstanding record.
   // ---------------------------------------------------------------------------
   logic [255:0]     mq[$];
   logic [255:0]     m_cur = '0;
   bit               m_running = 1'b0;
   bit               m_reporting = 1'b0;
   bit               m_start = 1'b0;
   bit               m_rv = 1'b0;
   bit               m_soft = 1'b0;
   bit               m_stat = 1'b0;
   logic [31:0]      m_ret = '0;
   logic [TAG_W-1:0] m_tag_out = '0;
   logic [TAG_W-1:0] m_next_tag = '0;
   logic [15:0]      m_done = '0;
   int               m_runcyc = 0;
   bit               m_acc;

   task automatic m_record(input logic [31:0] ret, input bit timed_out);
      m_ret       = ret;
      m_stat      = timed_out;
      m_tag_out   = m_next_tag;
      m_next_tag  = m_next_tag + 1'b1;
      m_start     = 1'b0;
      m_rv        = 1'b1;
      m_running   = 1'b0;
      m_reporting = 1'b1;
   endtask

   always @(posedge clk) begin
      m_acc = job_valid && (mq.size() < DEPTH);
      if (rst) begin
         mq.delete();
         m_cur = '0; m_running = 0; m_reporting = 0; m_start = 0; m_rv = 0;
         m_soft = 0; m_stat = 0; m_ret = '0; m_tag_out = '0; m_next_tag = '0;
         m_done = '0; m_runcyc = 0;
      end else begin
         m_soft = 1'b0;
         if (m_reporting) begin
            if (res_ready) begin
               m_rv = 1'b0;
               m_done = m_done + 16'd1;
               m_reporting = 1'b0;
            end
         end else if (m_running) begin
            m_runcyc++;
            if (k_done) m_record(k_ap_return, 1'b0);
`ifdef KSCHED_TIMEOUT_EN
            else if (m_runcyc == TOC) begin
               m_record(32'd0, 1'b1);
               m_soft = 1'b1;
            end
`endif
         end else if (mq.size() != 0) begin
            m_cur = mq.pop_front();
            m_start = 1'b1;
            m_running = 1'b1;
            m_runcyc = 0;
         end
         if (m_acc) mq.push_back(job_bits);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_job_ready",  job_ready, (mq.size() < DEPTH) ? 1 : 0);
         chk("m_busy",       busy, (m_running || m_reporting || mq.size() != 0) ? 1 : 0);
         chk("m_k_start",    k_start, m_start);
         chk("m_k_pargs",    k_pargs, m_cur[255:192]);
         chk("m_k_pdata",    k_pdata, m_cur[191:128]);
         chk("m_k_pres",     k_pres, m_cur[127:64]);
         chk("m_k_args_len", k_args_len, m_cur[63:32]);
         chk("m_k_data_len", k_data_len, m_cur[31:0]);
         chk("m_soft_reset", k_soft_reset, m_soft);
         chk("m_res_valid",  res_valid, m_rv);
         chk("m_res_return", res_return, m_ret);
         chk("m_res_tag",    res_tag, m_tag_out);
         chk("m_res_status", res_status, m_stat);
         chk("m_jobs_done",  jobs_done, m_done);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called at a falling edge, return at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic kdone(input logic [31:0] ret);
      k_done = 1'b1;
      k_ap_return = ret;
      @(negedge clk);
      k_done = 1'b0;
      k_ap_return = '0;
   endtask

   task automatic rdy();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1);
   end

   initial begin
      int cnt;
      rst = 1'b1; job_valid = 1'b0; job_bits = '0;
      k_done = 1'b0; k_ap_return = '0; res_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_k_start",   k_start, 0);
      chk("rst_job_ready", job_ready, 1);
      chk("rst_busy",      busy, 0);
      chk("rst_jobs_done", jobs_done, 0);
      chk("rst_res_valid", res_valid, 0);
      rst = 1'b0;

      // Single job, 20-cycle kernel
      job_valid = 1'b1;
      job_bits  = mkjob(64'd0, 64'd0, 64'd256, 32'd64, 32'd0);
      @(negedge clk);
      job_valid = 1'b0;
      chk("t2_no_start_yet", k_start, 0);
      @(negedge clk);
      chk("t2_start", k_start, 1);
      chk("t2_pres",  k_pres, 256);
      repeat (19) @(negedge clk);
      chk("t2_pres_stable", k_pres, 256);
      kdone(32'h24);
      chk("t2_res_valid", res_valid, 1);
      chk("t2_ret",       res_return, 32'h24);
      chk("t2_tag",       res_tag, 0);
      chk("t2_start_low", k_start, 0);
      rdy();
      chk("t2_jobs_done", jobs_done, 1);

      // Stalled kernel, six back-to-back pushes
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         job_valid = 1'b1;
         job_bits  = mkjob(64'h1000 + i, 64'h2000 + i, 64'h3000 + i, 32'h10 + i, 32'h20 + i);
         chk(i < 5 ? "t3_ready_accept" : "t3_ready_full", job_ready, i < 5 ? 1 : 0);
         @(negedge clk);
      end
      job_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         chk("t3_pargs", k_pargs, 64'h1000 + j);
         kdone(32'h100 + j);
         chk("t3_tag", res_tag, j);
         chk("t3_ret", res_return, 32'h100 + j);
         rdy();
         @(negedge clk);
      end
      chk("t3_idle_busy", busy, 0);
      chk("t3_jobs_done", jobs_done, 5);

      // Result held while consumer stalls, queued job waits
      do_reset(2);
      job_valid = 1'b1;
      job_bits  = mkjob(64'hA1, 64'hA2, 64'hA3, 32'hA4, 32'hA5);
      @(negedge clk);
      job_bits  = mkjob(64'hB1, 64'hB2, 64'hB3, 32'hB4, 32'hB5);
      @(negedge clk);
      job_valid = 1'b0;
      kdone(32'h55);
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold_valid", res_valid, 1);
         chk("t4_hold_start", k_start, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("t4_idle_start", k_start, 0);
      chk("t4_valid_drop", res_valid, 0);
      @(negedge clk);
      chk("t4_launch",   k_start, 1);
      chk("t4_pargs_B",  k_pargs, 64'hB1);
      kdone(32'h66);
      rdy();

      // Reset mid-RUN with jobs queued
      do_reset(2);
      job_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         job_bits = mkjob(64'h500 + i, 64'd0, 64'd0, 32'd0, 32'd0);
         @(negedge clk);
      end
      job_valid = 1'b0;
      @(negedge clk);
      chk("t5_running", k_start, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_start_low", k_start, 0);
      chk("t5_busy",      busy, 0);
      chk("t5_ready",     job_ready, 1);
      kdone(32'h77);
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_record", res_valid, 0);
         @(negedge clk);
      end
      chk("t5_jobs_done", jobs_done, 0);
      chk("t5_busy_after", busy, 0);

`ifdef KSCHED_TIMEOUT_EN
      // Watchdog abort, then a normal launch
      do_reset(2);
      job_valid = 1'b1;
      job_bits  = mkjob(64'hC1, 64'd0, 64'd0, 32'd0, 32'd0);
      @(negedge clk);
      job_bits  = mkjob(64'hD1, 64'd0, 64'd0, 32'd0, 32'd0);
      @(negedge clk);
      job_valid = 1'b0;
      cnt = 0;
      while (!k_soft_reset && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("t6_timeout_cycles", cnt, 100);
      chk("t6_soft",   k_soft_reset, 1);
      chk("t6_status", res_status, 1);
      chk("t6_ret",    res_return, 0);
      chk("t6_tag",    res_tag, 0);
      chk("t6_start",  k_start, 0);
      @(negedge clk);
      chk("t6_soft_pulse", k_soft_reset, 0);
      rdy();
      @(negedge clk);
      chk("t6_next_launch", k_start, 1);
      chk("t6_pargs_D",     k_pargs, 64'hD1);
      kdone(32'h99);
      chk("t6_ok_status", res_status, 0);
      chk("t6_ok_ret",    res_return, 32'h99);
      chk("t6_ok_tag",    res_tag, 1);
      rdy();
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
